// File: rtl/debouncer.sv
// ----------------------------------------------------------------------------
// debouncer
//   Multi-channel level debouncer. Each channel accepts a new level only after
//   DEBOUNCE_CYCLES consecutive samples disagree with the current level, then
//   emits a one-cycle rise or fall pulse. `changed` flags any pulse.
//
// Ports
//   clk      in   1      sole clock, all state updates on posedge
//   rst      in   1      synchronous active-high reset
//   sync_in  in   WIDTH  pre-synchronized channel inputs
//   level    out  WIDTH  debounced level per channel (registered)
//   rise     out  WIDTH  one-cycle pulse on accepted 0->1 (registered)
//   fall     out  WIDTH  one-cycle pulse on accepted 1->0 (registered)
//   changed  out  1      high exactly when any rise/fall bit is high
// ----------------------------------------------------------------------------

// Single-channel debounce FSM. pulse_d_o exposes the next-cycle pulse so the
// top can register `changed` in step with rise/fall.
module debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_d_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            mismatch;
    logic            accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        accept   = 1'b0;
        mismatch = sync_i ^ level_q;

        case (state_q)
            STABLE: begin
                if (mismatch) begin
                    // A single-cycle debounce is a plain follower.
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = PENDING;
                        cnt_d   = CW'(1);
                    end
                end
            end
            PENDING: begin
                if (!mismatch) begin
                    // Glitch: drop the partial count silently.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    // This sample is the DEBOUNCE_CYCLES-th mismatch.
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            level_d = sync_i;
            rise_d  = sync_i;
            fall_d  = ~sync_i;
            state_d = STABLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pulse_d_o = rise_d | fall_d;
endmodule

module debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    logic [WIDTH-1:0] pulse_d;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        debouncer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .sync_i   (sync_in[i]),
            .level_o  (level[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .pulse_d_o(pulse_d[i])
        );
    end

    // Registered from the lanes' next-state pulses so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= |pulse_d;
    end

    assign changed = changed_q;
endmodule

// File: tb/tb_debouncer.sv
module tb_debouncer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [1:0] in4 = 2'b00, in1 = 2'b00;
    logic [1:0] lv4, ri4, fa4, lv1, ri1, fa1;
    logic       ch4, ch1;

    debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .sync_in(in4),
        .level(lv4), .rise(ri4), .fall(fa4), .changed(ch4));

    debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .sync_in(in1),
        .level(lv1), .rise(ri1), .fall(fa1), .changed(ch1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a channel adopts a new level when the last DC samples
    // taken since reset all disagree with its current level.
    logic [1:0] q4[$];
    logic [1:0] q1[$];
    logic [1:0] m4_lvl = 0, m4_rise = 0, m4_fall = 0;
    logic [1:0] m1_lvl = 0, m1_rise = 0, m1_fall = 0;
    logic       m4_chg = 0, m1_chg = 0;

    function automatic bit win4(int ch);
        if (q4.size() < 4) return 1'b0;
        for (int j = q4.size() - 4; j < q4.size(); j++)
            if (q4[j][ch] == m4_lvl[ch]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit win1(int ch);
        if (q1.size() < 1) return 1'b0;
        return q1[q1.size() - 1][ch] != m1_lvl[ch];
    endfunction

    // One clock: drive away from the edge, advance the model at the edge,
    // leave time positioned 1 unit after the edge for sampling.
    task automatic tick(input logic [1:0] s4, input logic [1:0] s1, input logic r);
        @(negedge clk);
        in4 = s4; in1 = s1; rst = r;
        @(posedge clk);
        m4_rise = 0; m4_fall = 0; m1_rise = 0; m1_fall = 0;
        if (r) begin
            m4_lvl = 0; m1_lvl = 0;
            q4.delete(); q1.delete();
        end else begin
            q4.push_back(s4); q1.push_back(s1);
            if (q4.size() > 16) void'(q4.pop_front());
            if (q1.size() > 16) void'(q1.pop_front());
            for (int ch = 0; ch < 2; ch++) begin
                if (win4(ch)) begin
                    m4_lvl[ch] = s4[ch];
                    if (s4[ch]) m4_rise[ch] = 1'b1; else m4_fall[ch] = 1'b1;
                end
                if (win1(ch)) begin
                    m1_lvl[ch] = s1[ch];
                    if (s1[ch]) m1_rise[ch] = 1'b1; else m1_fall[ch] = 1'b1;
                end
            end
        end
        m4_chg = |(m4_rise | m4_fall);
        m1_chg = |(m1_rise | m1_fall);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(2'($urandom), 2'($urandom), 1'b1);
            n_checks++;
            if ({lv4, ri4, fa4, ch4, lv1, ri1, fa1, ch1} !== 14'b0) begin
                n_fail++;
                $display("FAIL reset k=%0d got4=%b/%b/%b/%b got1=%b/%b/%b/%b expected all zero",
                         k, lv4, ri4, fa4, ch4, lv1, ri1, fa1, ch1);
            end
        end
    endtask

    task automatic test_clean_step();
        for (int k = 0; k < 3; k++) tick(2'b00, 2'b00, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            logic el, er;
            tick(2'b01, 2'b00, 1'b0);
            el = (i >= 4);
            er = (i == 4);
            n_checks++;
            if ({lv4[0], ri4[0], fa4[0], ch4} !== {el, er, 1'b0, er}) begin
                n_fail++;
                $display("FAIL clean_step i=%0d lvl/rise/fall/chg got %b%b%b%b expected %b%b0%b",
                         i, lv4[0], ri4[0], fa4[0], ch4, el, er, er);
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] pat[6] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
        for (int k = 0; k < 6; k++) begin
            tick(pat[k], 2'b00, 1'b0);
            n_checks++;
            if ({lv4, ri4, fa4, ch4} !== 7'b01_00_00_0) begin
                n_fail++;
                $display("FAIL glitch k=%0d got lvl=%b rise=%b fall=%b chg=%b expected 01/00/00/0",
                         k, lv4, ri4, fa4, ch4);
            end
        end
    endtask

    task automatic test_bounce_fall();
        logic pat[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            logic ef, el;
            tick({1'b0, pat[k]}, 2'b00, 1'b0);
            ef = (k == 5);
            el = (k < 5);
            n_checks++;
            if ({lv4[0], fa4[0], ri4[0], ch4} !== {el, ef, 1'b0, ef}) begin
                n_fail++;
                $display("FAIL bounce_fall k=%0d lvl/fall/rise/chg got %b%b%b%b expected %b%b0%b",
                         k, lv4[0], fa4[0], ri4[0], ch4, el, ef, ef);
            end
        end
    endtask

    task automatic test_back_to_back_simultaneous();
        int nr = 0, nc = 0, nf = 0;
        for (int k = 0; k < 6; k++) begin
            tick(2'b11, 2'b00, 1'b0);
            if (ri4 == 2'b11) nr++;
            if (ch4) nc++;
            if (k == 3) begin
                n_checks++;
                if (ri4 !== 2'b11 || lv4 !== 2'b11) begin
                    n_fail++;
                    $display("FAIL simul_rise_k3 got rise=%b lvl=%b expected 11/11", ri4, lv4);
                end
            end
        end
        n_checks++;
        if (nr != 1 || nc != 1) begin
            n_fail++;
            $display("FAIL simul_rise_count got rise_cycles=%0d chg_cycles=%0d expected 1/1", nr, nc);
        end
        for (int k = 0; k < 6; k++) begin
            tick(2'b00, 2'b00, 1'b0);
            if (fa4 == 2'b11 && ch4) nf++;
        end
        n_checks++;
        if (nf != 1 || lv4 !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_fall got fall_cycles=%0d lvl=%b expected 1/00", nf, lv4);
        end
    endtask

    task automatic test_reset_mid_count();
        tick(2'b01, 2'b00, 1'b0);
        tick(2'b01, 2'b00, 1'b0);
        tick(2'b01, 2'b00, 1'b1);
        n_checks++;
        if ({lv4, ri4, fa4, ch4} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_during got lvl=%b rise=%b fall=%b chg=%b expected zeros",
                     lv4, ri4, fa4, ch4);
        end
        for (int k = 0; k < 6; k++) begin
            logic er, el;
            tick(2'b01, 2'b00, 1'b0);
            er = (k == 3);
            el = (k >= 3);
            n_checks++;
            if ({lv4[0], ri4[0], ch4} !== {el, er, er}) begin
                n_fail++;
                $display("FAIL reset_mid_after k=%0d lvl/rise/chg got %b%b%b expected %b%b%b",
                         k, lv4[0], ri4[0], ch4, el, er, er);
            end
        end
    endtask

    task automatic test_dc1_follow();
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k % 2 == 0);
            tick(in4, {1'b0, v}, 1'b0);
            n_checks++;
            if ({lv1[0], ri1[0], fa1[0], ch1} !== {v, v, ~v, 1'b1}) begin
                n_fail++;
                $display("FAIL dc1_follow k=%0d lvl/rise/fall/chg got %b%b%b%b expected %b%b%b1",
                         k, lv1[0], ri1[0], fa1[0], ch1, v, v, ~v);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] s4 = in4;
        for (int k = 0; k < 800; k++) begin
            logic r;
            for (int ch = 0; ch < 2; ch++)
                if ($urandom_range(0, 3) == 0) s4[ch] = ~s4[ch];
            r = ($urandom_range(0, 79) == 0);
            tick(s4, 2'($urandom), r);
            n_checks++;
            if ({lv4, ri4, fa4, ch4} !== {m4_lvl, m4_rise, m4_fall, m4_chg} || (ri4 & fa4) != 0) begin
                n_fail++;
                $display("FAIL random_dc4 k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b",
                         k, lv4, ri4, fa4, ch4, m4_lvl, m4_rise, m4_fall, m4_chg);
            end
            n_checks++;
            if ({lv1, ri1, fa1, ch1} !== {m1_lvl, m1_rise, m1_fall, m1_chg}) begin
                n_fail++;
                $display("FAIL random_dc1 k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b",
                         k, lv1, ri1, fa1, ch1, m1_lvl, m1_rise, m1_fall, m1_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce_fall();
        test_back_to_back_simultaneous();
        test_reset_mid_count();
        test_dc1_follow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 Parameter WIDTH, default 8: number of independent input channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive mismatching cycles required to accept a new level (>=1).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sync_in  input  WIDTH  already-synchronized channel inputs, sampled every posedge.
REQ-006 level  output  WIDTH  debounced, registered level per channel.
REQ-007 rise  output  WIDTH  one-cycle registered pulse per channel on accepted 0->1 change.
REQ-008 fall  output  WIDTH  one-cycle registered pulse per channel on accepted 1->0 change.
REQ-009 changed  output  1  registered; high in exactly the cycles where any rise or fall bit is high.

Function
REQ-010 Each channel SHALL be independent: one level flop, one counter of width $clog2(DEBOUNCE_CYCLES+1), and a two-state FSM (STABLE, PENDING).
REQ-011 STABLE: counter is 0; when sync_in[i] != level[i] at an edge and DEBOUNCE_CYCLES > 1, the channel SHALL go to PENDING with counter = 1.
REQ-012 PENDING: at each edge with sync_in[i] != level[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 PENDING: at an edge with sync_in[i] == level[i] (glitch), the channel SHALL return to STABLE, counter = 0, no pulse.
REQ-014 At the edge that is the DEBOUNCE_CYCLES-th consecutive mismatching sample, level[i] SHALL take sync_in[i], counter = 0, state = STABLE.
REQ-015 At that same edge, rise[i] SHALL be set if the new level is 1, otherwise fall[i]; the pulse SHALL clear at the next edge unconditionally.
REQ-016 Latency: a clean input change first sampled at edge k SHALL appear on level at edge k+DEBOUNCE_CYCLES-1 (visible the cycle after that edge).
REQ-017 DEBOUNCE_CYCLES = 1: every mismatching sample SHALL be accepted at the edge it is sampled (one-cycle follower with edge pulses); PENDING is never entered.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 rise[i] and fall[i] SHALL never be high in the same cycle; back-to-back pulses on one channel SHALL be separated by at least DEBOUNCE_CYCLES-1 cycles of no pulse (for DEBOUNCE_CYCLES > 1).
REQ-020 Simultaneous accepted changes on several channels SHALL each produce their own pulse in the same cycle; changed SHALL be a single-cycle high.
REQ-021 A glitch of DEBOUNCE_CYCLES-1 or fewer cycles SHALL produce no change on any output.

Reset
REQ-022 While rst is high at a posedge: level, rise, fall, changed SHALL be 0, all counters 0, all FSMs STABLE.
REQ-023 Reset asserted mid-PENDING SHALL discard the partial count; no pulse SHALL be emitted for that count, during or after reset.
REQ-024 After rst deasserts, a channel whose sync_in is 1 SHALL be treated as a fresh 0->1 change and be accepted per REQ-014 with a rise pulse.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4 unless noted)
REQ-025 Clean step: sync_in[0] 0->1 held, first sampled at edge k -> level[0]=1 and rise[0]=1 after edge k+3, rise[0]=0 after edge k+4, changed mirrors rise.
REQ-026 Glitch: sync_in[1] high for 3 edges then low -> level, rise, fall, changed stay 0 throughout.
REQ-027 Falling edge with bounce: level[0]=1; sync_in[0] pattern 0,1,0,0,0,0 -> single fall[0] pulse after the 4th consecutive 0 sample, none earlier.
REQ-028 Simultaneous: both bits 0->1 at the same edge -> rise=2'b11 for exactly one cycle, changed=1 for exactly one cycle.
REQ-029 Reset mid-count: sync_in[0]=1 for 2 edges, rst high for 1 edge, sync_in[0] kept 1 -> all outputs 0 during reset, rise[0] only after 4 further post-reset samples.
REQ-030 DEBOUNCE_CYCLES=1: toggling sync_in[0] every cycle -> level[0] follows with one-cycle latency, alternating rise/fall pulses every cycle.
